// File: rtl/fft_mm_pkg.sv
// Register map, control/status bit positions and FSM encoding for fft_mm_bridge.
package fft_mm_pkg;
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] IN_R_BASE  = 8'h10;
  localparam logic [7:0] IN_I_BASE  = 8'h20;
  localparam logic [7:0] OUT_R_BASE = 8'h30;
  localparam logic [7:0] OUT_I_BASE = 8'h40;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int ST_DONE        = 0;
  localparam int ST_BUSY        = 1;
  localparam int ST_ERR_BUSY    = 2;
  localparam int ST_ERR_TIMEOUT = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_DRAIN} state_e;
endpackage

// File: rtl/fft_mm_bridge_fft.sv
// Serial DFT core: one complex MAC per cycle, N*N cycles per transform.
// Level handshake: done rises when all bins are ready and holds until start drops.
// Twiddles are Q14 from a 16-entry cosine table, exact for N <= 4.
module fft #(
  parameter int N_POINTS = 4,
  parameter int SAMPLE_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_POINTS*SAMPLE_W-1:0] xr,
  input  logic [N_POINTS*SAMPLE_W-1:0] xi,
  output logic                         done,
  output logic [N_POINTS*SAMPLE_W-1:0] out_r,
  output logic [N_POINTS*SAMPLE_W-1:0] out_i
);
  localparam int IW = $clog2(N_POINTS);
  localparam int AW = SAMPLE_W + 22;  // 16b twiddle + sum growth + headroom

  function automatic logic signed [15:0] cos16(input logic [3:0] i);
    case (i)
      4'd0:  return 16'sd16384;  4'd1:  return 16'sd15137;
      4'd2:  return 16'sd11585;  4'd3:  return 16'sd6270;
      4'd4:  return 16'sd0;      4'd5:  return -16'sd6270;
      4'd6:  return -16'sd11585; 4'd7:  return -16'sd15137;
      4'd8:  return -16'sd16384; 4'd9:  return -16'sd15137;
      4'd10: return -16'sd11585; 4'd11: return -16'sd6270;
      4'd12: return 16'sd0;      4'd13: return 16'sd6270;
      4'd14: return 16'sd11585;  default: return 16'sd15137;
    endcase
  endfunction

  logic [IW-1:0] n_q, n_d, k_q, k_d, m;
  logic [3:0] tw;
  logic signed [AW-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic signed [AW-1:0] c, s, xs_r, xs_i, sum_r, sum_i;
  logic [SAMPLE_W-1:0] rnd_r, rnd_i;
  logic done_q, done_d;
  logic [N_POINTS*SAMPLE_W-1:0] out_r_q, out_r_d, out_i_q, out_i_d;

  // MAC step: accumulate x[n]*W^(n*k); on the last n round the bin into the output.
  always_comb begin
    m     = IW'(n_q * k_q);
    tw    = 4'(m) << (4 - IW);
    c     = AW'(cos16(tw));
    s     = AW'(cos16(tw - 4'd4));  // sin(a) = cos(a - 90deg)
    xs_r  = AW'($signed(xr[n_q*SAMPLE_W +: SAMPLE_W]));
    xs_i  = AW'($signed(xi[n_q*SAMPLE_W +: SAMPLE_W]));
    sum_r = acc_r_q + xs_r * c + xs_i * s;
    sum_i = acc_i_q + xs_i * c - xs_r * s;
    rnd_r = SAMPLE_W'((sum_r + AW'(8192)) >>> 14);
    rnd_i = SAMPLE_W'((sum_i + AW'(8192)) >>> 14);
    n_d = n_q; k_d = k_q; acc_r_d = acc_r_q; acc_i_d = acc_i_q;
    done_d = done_q; out_r_d = out_r_q; out_i_d = out_i_q;
    if (!start) begin
      n_d = '0; k_d = '0; acc_r_d = '0; acc_i_d = '0; done_d = 1'b0;
    end else if (!done_q) begin
      if (n_q == IW'(N_POINTS - 1)) begin
        out_r_d[k_q*SAMPLE_W +: SAMPLE_W] = rnd_r;
        out_i_d[k_q*SAMPLE_W +: SAMPLE_W] = rnd_i;
        acc_r_d = '0; acc_i_d = '0; n_d = '0;
        if (k_q == IW'(N_POINTS - 1)) begin
          done_d = 1'b1; k_d = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end else begin
        acc_r_d = sum_r; acc_i_d = sum_i; n_d = n_q + 1'b1;
      end
    end
  end

  // Core state register, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= '0; k_q <= '0; acc_r_q <= '0; acc_i_q <= '0;
      done_q <= 1'b0; out_r_q <= '0; out_i_q <= '0;
    end else begin
      n_q <= n_d; k_q <= k_d; acc_r_q <= acc_r_d; acc_i_q <= acc_i_d;
      done_q <= done_d; out_r_q <= out_r_d; out_i_q <= out_i_d;
    end
  end

  assign done  = done_q;
  assign out_r = out_r_q;
  assign out_i = out_i_q;
endmodule

// File: rtl/fft_mm_bridge.sv
// Avalon-MM slave wrapping the fft core: input/result buffers, control FSM,
// watchdog, status flags and level interrupt.
module fft_mm_bridge import fft_mm_pkg::*; #(
  parameter int N_POINTS    = 4,
  parameter int SAMPLE_W    = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq
);
  localparam int BW = N_POINTS * SAMPLE_W;

  state_e state_q, state_d;
  logic [BW-1:0] in_r_q, in_r_d, in_i_q, in_i_d, res_r_q, res_r_d, res_i_q, res_i_d;
  logic irq_en_q, irq_en_d, done_q, done_d, err_busy_q, err_busy_d, err_to_q, err_to_d;
  logic core_rst_q, core_rst_d;
  logic [31:0] wd_q, wd_d, rdata_q, rdata_d;
  logic core_done, start_go, busy, k_ok;
  logic hit_in_r, hit_in_i, hit_out_r, hit_out_i;
  logic [3:0] k;
  logic [BW-1:0] core_out_r, core_out_i;

  function automatic logic [31:0] sext(input logic [SAMPLE_W-1:0] v);
    return 32'($signed(v));
  endfunction

  assign busy      = (state_q != S_IDLE);
  assign k         = address[3:0];
  assign k_ok      = int'(k) < N_POINTS;
  assign hit_in_r  = k_ok && (address[7:4] == IN_R_BASE[7:4]);
  assign hit_in_i  = k_ok && (address[7:4] == IN_I_BASE[7:4]);
  assign hit_out_r = k_ok && (address[7:4] == OUT_R_BASE[7:4]);
  assign hit_out_i = k_ok && (address[7:4] == OUT_I_BASE[7:4]);

  // Read mux over pre-write state, so a colliding write is not seen.
  always_comb begin
    rdata_d = '0;
    if (read) begin
      if (address == REG_CTRL) begin
        rdata_d[CTRL_IRQ_EN] = irq_en_q;
      end else if (address == REG_STATUS) begin
        rdata_d[ST_DONE]        = done_q;
        rdata_d[ST_BUSY]        = busy;
        rdata_d[ST_ERR_BUSY]    = err_busy_q;
        rdata_d[ST_ERR_TIMEOUT] = err_to_q;
        rdata_d[15:8]           = 8'(N_POINTS);
      end else if (hit_in_r)  rdata_d = sext(in_r_q[k*SAMPLE_W +: SAMPLE_W]);
      else if (hit_in_i)      rdata_d = sext(in_i_q[k*SAMPLE_W +: SAMPLE_W]);
      else if (hit_out_r)     rdata_d = sext(res_r_q[k*SAMPLE_W +: SAMPLE_W]);
      else if (hit_out_i)     rdata_d = sext(res_i_q[k*SAMPLE_W +: SAMPLE_W]);
    end
  end

  // Bus writes first, then FSM events, so a CAPTURE DONE-set beats a same-cycle CLR.
  always_comb begin
    state_d = state_q; in_r_d = in_r_q; in_i_d = in_i_q; res_r_d = res_r_q; res_i_d = res_i_q;
    irq_en_d = irq_en_q; done_d = done_q; err_busy_d = err_busy_q; err_to_d = err_to_q;
    core_rst_d = 1'b0; wd_d = wd_q; start_go = 1'b0;
    if (write) begin
      if (address == REG_CTRL) begin
        irq_en_d = writedata[CTRL_IRQ_EN];
        if (writedata[CTRL_CLR]) begin
          done_d = 1'b0; err_busy_d = 1'b0; err_to_d = 1'b0;
        end
        if (writedata[CTRL_START]) begin
          if (busy) err_busy_d = 1'b1;
          else      start_go   = 1'b1;
        end
      end else if (hit_in_r || hit_in_i) begin
        if (busy)          err_busy_d = 1'b1;
        else if (hit_in_r) in_r_d[k*SAMPLE_W +: SAMPLE_W] = writedata[SAMPLE_W-1:0];
        else               in_i_d[k*SAMPLE_W +: SAMPLE_W] = writedata[SAMPLE_W-1:0];
      end
    end
    case (state_q)
      S_IDLE: if (start_go) begin
        state_d = S_RUN; done_d = 1'b0; wd_d = '0;
      end
      S_RUN: begin
        wd_d = wd_q + 32'd1;
        if (core_done) begin
          state_d = S_CAPTURE;
        end else if (TIMEOUT_CYC != 0 && wd_d == 32'(TIMEOUT_CYC)) begin
          // abort: pulse core reset, keep the old results
          err_to_d = 1'b1; core_rst_d = 1'b1; state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        res_r_d = core_out_r; res_i_d = core_out_i; done_d = 1'b1; state_d = S_DRAIN;
      end
      S_DRAIN: if (!core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register file, FSM and watchdog state; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE; in_r_q <= '0; in_i_q <= '0; res_r_q <= '0; res_i_q <= '0;
      irq_en_q <= 1'b0; done_q <= 1'b0; err_busy_q <= 1'b0; err_to_q <= 1'b0;
      core_rst_q <= 1'b0; wd_q <= '0; rdata_q <= '0;
    end else begin
      state_q <= state_d; in_r_q <= in_r_d; in_i_q <= in_i_d; res_r_q <= res_r_d; res_i_q <= res_i_d;
      irq_en_q <= irq_en_d; done_q <= done_d; err_busy_q <= err_busy_d; err_to_q <= err_to_d;
      core_rst_q <= core_rst_d; wd_q <= wd_d; rdata_q <= rdata_d;
    end
  end

  fft #(.N_POINTS(N_POINTS), .SAMPLE_W(SAMPLE_W)) fft_inst (
    .clk   (clk),
    .rst   (~reset_n | core_rst_q),
    .start (state_q == S_RUN),
    .xr    (in_r_q),
    .xi    (in_i_q),
    .done  (core_done),
    .out_r (core_out_r),
    .out_i (core_out_i)
  );

  assign readdata    = rdata_q;
  assign waitrequest = 1'b0;
  assign irq         = done_q & irq_en_q;
endmodule

// File: tb/tb_fft_mm_bridge.sv
// Randomized bench for fft_mm_bridge against a DFT reference model. A second
// instance with an 8-cycle watchdog (shorter than the 16-cycle core) covers abort.
module tb_fft_mm_bridge;
  localparam int N = 4;
  localparam logic [7:0] A_CTRL = 8'h00, A_STAT = 8'h01;
  localparam logic [7:0] A_INR = 8'h10, A_INI = 8'h20, A_OUTR = 8'h30, A_OUTI = 8'h40;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] address = '0;
  logic write = 1'b0, read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] rd0, rd1;
  logic wr0, wr1, irq0, irq1;

  always #5 clk = ~clk;

  fft_mm_bridge #(.N_POINTS(N), .SAMPLE_W(32), .TIMEOUT_CYC(4096)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
    .writedata(writedata), .readdata(rd0), .waitrequest(wr0), .irq(irq0));
  fft_mm_bridge #(.N_POINTS(N), .SAMPLE_W(32), .TIMEOUT_CYC(8)) dut_to (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
    .writedata(writedata), .readdata(rd1), .waitrequest(wr1), .irq(irq1));

  int total = 0, bad = 0;
  logic [31:0] m_in_r[N], m_in_i[N], m_res_r[N], m_res_i[N];
  logic m_irq_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // X[k] = sum x[n] * exp(-j*2*pi*n*k/N); for N=4 the twiddles are 1, -j, -1, j.
  task automatic model_fft();
    for (int kk = 0; kk < N; kk++) begin
      longint sr = 0, si = 0;
      for (int nn = 0; nn < N; nn++) begin
        longint xr = longint'($signed(m_in_r[nn]));
        longint xi = longint'($signed(m_in_i[nn]));
        case ((nn * kk) % N)
          0: begin sr += xr; si += xi; end
          1: begin sr += xi; si -= xr; end
          2: begin sr -= xr; si -= xi; end
          default: begin sr -= xi; si += xr; end
        endcase
      end
      m_res_r[kk] = sr[31:0];
      m_res_i[kk] = si[31:0];
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); address = a; writedata = d; write = 1'b1;
    @(negedge clk); write = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d0, output logic [31:0] d1);
    @(negedge clk); address = a; read = 1'b1;
    @(posedge clk); #1; d0 = rd0; d1 = rd1; read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d0, d1;
    bus_rd(a, d0, d1);
    chk(tag, d0, exp);
  endtask

  task automatic load_inputs();
    for (int i = 0; i < N; i++) begin
      bus_wr(A_INR + 8'(i), m_in_r[i]);
      bus_wr(A_INI + 8'(i), m_in_i[i]);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_chk({tag, "_re"}, A_OUTR + 8'(i), m_res_r[i]);
      rd_chk({tag, "_im"}, A_OUTI + 8'(i), m_res_i[i]);
    end
  endtask

  task automatic wait_done();
    logic [31:0] s0, s1;
    s0 = '0;
    for (int i = 0; i < 100; i++) begin
      bus_rd(A_STAT, s0, s1);
      if (s0[0]) break;
    end
    chk("done_wait", {31'd0, s0[0]}, 32'd1);
  endtask

  task automatic run_xform(input string tag);
    bus_wr(A_CTRL, {30'd0, m_irq_en, 1'b1});
    wait_done();
    model_fft();
    check_results(tag);
    @(negedge clk);
    chk({tag, "_irq"}, {31'd0, irq0}, {31'd0, m_irq_en});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] s0, s1, d0, d1;
    for (int i = 0; i < N; i++) begin
      m_in_r[i] = '0; m_in_i[i] = '0; m_res_r[i] = '0; m_res_i[i] = '0;
    end
    m_irq_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", rd0, 32'd0);
    chk("rst_irq", {31'd0, irq0}, 32'd0);
    chk("rst_waitreq", {31'd0, wr0}, 32'd0);
    reset_n = 1'b1;
    bus_rd(A_STAT, s0, s1);
    chk("rst_status", s0, 32'h0400);
    chk("rst_status_to", s1, 32'h0400);

    // impulse with interrupt enabled
    m_in_r[0] = 32'd1;
    load_inputs();
    m_irq_en = 1'b1;
    bus_wr(A_CTRL, 32'h2);
    bus_wr(A_CTRL, 32'h3);
    bus_rd(A_STAT, s0, s1);
    chk("imp_busy", s0 & 32'h3, 32'h2);
    wait_done();
    model_fft();
    check_results("imp");
    @(negedge clk);
    chk("imp_irq", {31'd0, irq0}, 32'd1);
    chk("imp_expect_r1", m_res_r[1], 32'd1);
    rd_chk("ctrl_rb", A_CTRL, 32'h2);

    // DC, then CLR
    for (int i = 0; i < N; i++) m_in_r[i] = 32'd1;
    load_inputs();
    run_xform("dc");
    chk("dc_expect_r0", m_res_r[0], 32'd4);
    bus_wr(A_CTRL, 32'h6);
    chk("clr_irq", {31'd0, irq0}, 32'd0);
    rd_chk("clr_status", A_STAT, 32'h0400);

    // reset in the middle of a run
    for (int i = 0; i < N; i++) m_in_r[i] = 32'(i + 2);
    load_inputs();
    bus_wr(A_CTRL, 32'h3);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_in_r[i] = '0; m_in_i[i] = '0; m_res_r[i] = '0; m_res_i[i] = '0;
    end
    m_irq_en = 1'b0;
    bus_rd(A_STAT, s0, s1);
    chk("mrst_status", s0, 32'h0400);
    chk("mrst_status_to", s1, 32'h0400);
    chk("mrst_irq", {31'd0, irq0}, 32'd0);
    for (int i = 0; i < N; i++) begin
      rd_chk("mrst_in_r", A_INR + 8'(i), 32'd0);
      rd_chk("mrst_in_i", A_INI + 8'(i), 32'd0);
    end
    check_results("mrst_res");

    // random transforms
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin
        m_in_r[i] = $urandom;
        m_in_i[i] = (t < 2) ? 32'($signed(16'($urandom))) : $urandom;
      end
      m_irq_en = 1'($urandom);
      load_inputs();
      run_xform("rnd");
    end

    // busy protection
    for (int i = 0; i < N; i++) begin m_in_r[i] = $urandom; m_in_i[i] = $urandom; end
    load_inputs();
    d0 = m_res_r[0];
    m_irq_en = 1'b1;
    bus_wr(A_CTRL, 32'h3);
    bus_wr(A_INR, 32'h55);
    bus_wr(A_CTRL, 32'h3);
    bus_rd(A_STAT, s0, s1);
    chk("busy_flags", s0 & 32'h6, 32'h6);
    rd_chk("busy_oldres", A_OUTR, d0);
    wait_done();
    model_fft();
    check_results("busy");
    rd_chk("busy_in_r0", A_INR, m_in_r[0]);
    repeat (30) @(negedge clk);
    rd_chk("busy_single", A_STAT, 32'h0405);

    // watchdog abort on the short-timeout instance
    bus_wr(A_CTRL, 32'h6);
    bus_wr(A_CTRL, 32'h3);
    repeat (6) @(negedge clk);
    bus_rd(A_STAT, s0, s1);
    chk("to_run8", s1 & 32'hF, 32'h2);
    bus_rd(A_STAT, s0, s1);
    chk("to_abort", s1, 32'h0408);
    for (int i = 0; i < N; i++) begin
      bus_rd(A_OUTR + 8'(i), d0, d1);
      chk("to_res_kept", d1, 32'd0);
    end
    wait_done();
    model_fft();
    check_results("to_main");
    rd_chk("to_main_noerr", A_STAT, 32'h0401);

    // out-of-range and unmapped addresses
    bus_wr(8'h34, 32'hDEADBEEF);
    bus_wr(8'h14, 32'h12345678);
    rd_chk("oor_34", 8'h34, 32'd0);
    rd_chk("oor_14", 8'h14, 32'd0);
    rd_chk("unmapped_05", 8'h05, 32'd0);
    rd_chk("oor_in_r0", A_INR, m_in_r[0]);
    rd_chk("lat_30", A_OUTR, m_res_r[0]);

    // colliding read and write: read sees the old value
    d1 = $urandom;
    @(negedge clk); address = A_INR + 8'd1; writedata = d1; write = 1'b1; read = 1'b1;
    @(posedge clk); #1; d0 = rd0; write = 1'b0; read = 1'b0;
    chk("rw_old", d0, m_in_r[1]);
    m_in_r[1] = d1;
    rd_chk("rw_new", A_INR + 8'd1, m_in_r[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
